// File: rtl/register_bank.sv
// Parameterised register bank with combinational read port, per-register valid mask and a
// multi-cycle bulk clear. Optional same-cycle write-to-read bypass: define REGISTER_BANK_BYPASS_EN.
module register_bank #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      WriteEnable,
  input  logic [$clog2(DEPTH)-1:0]  WriteAddr,
  input  logic [WIDTH-1:0]          DataIn,
  input  logic                      ReadEnable,
  input  logic [$clog2(DEPTH)-1:0]  ReadAddr,
  output logic [WIDTH-1:0]          DataOut,
  input  logic                      ClearRequest,
  output logic                      Ready,
  output logic [DEPTH-1:0]          ValidMask,
  output logic [WIDTH*DEPTH-1:0]    AlwaysOnDataOut
);

  localparam int                ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic [WIDTH-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]  valid_mask;
  logic              wr_in_range;
  logic              rd_in_range;

  // Non-power-of-two depths leave address codes with no backing register.
  assign wr_in_range = ({1'b0, WriteAddr} < DEPTH_L);
  assign rd_in_range = ({1'b0, ReadAddr} < DEPTH_L);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      valid_mask <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= INIT_VALUE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ClearRequest) begin
            state   <= CLEAR;
            counter <= '0;
          end else if (WriteEnable && wr_in_range) begin
            regs[WriteAddr]       <= DataIn;
            valid_mask[WriteAddr] <= 1'b1;
          end
        end
        CLEAR: begin
          regs[counter]       <= INIT_VALUE;
          valid_mask[counter] <= 1'b0;
          if (counter == LAST) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  assign Ready     = (state == IDLE);
  assign ValidMask = valid_mask;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign AlwaysOnDataOut[g*WIDTH +: WIDTH] = regs[g];
  end

  always_comb begin
    DataOut = '0;
    if (ReadEnable && rd_in_range) begin
      DataOut = regs[ReadAddr];
`ifdef REGISTER_BANK_BYPASS_EN
      // Forward only a write that will actually land at this edge.
      if (!reset && state == IDLE && !ClearRequest && WriteEnable && wr_in_range &&
          ReadAddr == WriteAddr) begin
        DataOut = DataIn;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Randomised self-checking bench for register_bank with an array-based behavioural model,
// plus directed literal checks (default 8x32 instance and a 6-deep instance).
module tb_register_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic         reset, we, re, cr;
  logic [2:0]   wa, ra;
  logic [31:0]  din, dout;
  logic         ready;
  logic [7:0]   vmask;
  logic [255:0] aodo;

  // DEPTH=6 instance with nonzero INIT_VALUE
  logic         s_reset, s_we, s_re, s_cr;
  logic [2:0]   s_wa, s_ra;
  logic [7:0]   s_din, s_dout;
  logic         s_ready;
  logic [5:0]   s_vmask;
  logic [47:0]  s_aodo;

  register_bank dut (
    .clock(clk), .reset(reset), .WriteEnable(we), .WriteAddr(wa), .DataIn(din),
    .ReadEnable(re), .ReadAddr(ra), .DataOut(dout), .ClearRequest(cr), .Ready(ready),
    .ValidMask(vmask), .AlwaysOnDataOut(aodo)
  );

  register_bank #(.WIDTH(8), .DEPTH(6), .INIT_VALUE(8'h3C)) dut6 (
    .clock(clk), .reset(s_reset), .WriteEnable(s_we), .WriteAddr(s_wa), .DataIn(s_din),
    .ReadEnable(s_re), .ReadAddr(s_ra), .DataOut(s_dout), .ClearRequest(s_cr), .Ready(s_ready),
    .ValidMask(s_vmask), .AlwaysOnDataOut(s_aodo)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model of the default instance
  logic [31:0] m_regs [8];
  logic [7:0]  m_valid;
  bit          m_clearing;
  int          m_left;

  task automatic model_init();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    m_valid    = 8'h0;
    m_clearing = 1'b0;
    m_left     = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_init();
    end else if (m_clearing) begin
      m_regs[8 - m_left]  = 32'h0;
      m_valid[8 - m_left] = 1'b0;
      m_left--;
      if (m_left == 0) m_clearing = 1'b0;
    end else if (cr) begin
      m_clearing = 1'b1;
      m_left     = 8;
    end else if (we) begin
      m_regs[wa]  = din;
      m_valid[wa] = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0]  e;
    logic [255:0] ea;
    if (cmp_en) begin
      e = re ? m_regs[ra] : 32'h0;
`ifdef REGISTER_BANK_BYPASS_EN
      if (!reset && !m_clearing && !cr && we && re && wa == ra) e = din;
`endif
      for (int i = 0; i < 8; i++) ea[i*32 +: 32] = m_regs[i];
      check("dout", 256'(dout), 256'(e));
      check("ready", 256'(ready), 256'(!m_clearing));
      check("valid", 256'(vmask), 256'(m_valid));
      check("aodo", aodo, ea);
    end
  end

  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); din = $urandom | 32'h1;
      @(posedge clk); #1;
    end
    we = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b0; we = 0; re = 0; cr = 0; wa = 0; ra = 0; din = 0;
    s_reset = 1'b0; s_we = 0; s_re = 0; s_cr = 0; s_wa = 0; s_ra = 0; s_din = 0;
    #2;
    reset = 1'b1; s_reset = 1'b1;
    #1 cmp_en = 1'b1;

    // DEPTH=6 instance: read during reset, out-of-range write/read, bypass behaviour
    s_re = 1'b1; s_ra = 3'd1; s_we = 1'b1; s_wa = 3'd1; s_din = 8'hEE;
    @(negedge clk);
    check("s_reset_read", 256'(s_dout), 256'(8'h3C));
    check("s_reset_ready", 256'(s_ready), 256'(1'b1));
    @(posedge clk); #1;
    s_reset = 1'b0; s_we = 1'b1; s_wa = 3'd7; s_din = 8'h55; s_ra = 3'd7;
    @(negedge clk);
    check("s_oob_read", 256'(s_dout), 256'(8'h00));
    @(posedge clk); #1;
    s_we = 1'b1; s_wa = 3'd5; s_din = 8'h77; s_ra = 3'd5;
    @(negedge clk);
    check("s_oob_valid", 256'(s_vmask), 256'(6'h00));
    check("s_oob_aodo", 256'(s_aodo), 256'({6{8'h3C}}));
`ifdef REGISTER_BANK_BYPASS_EN
    check("s_bypass", 256'(s_dout), 256'(8'h77));
`else
    check("s_nobypass", 256'(s_dout), 256'(8'h3C));
`endif
    @(posedge clk); #1;
    s_we = 1'b0;
    @(negedge clk);
    check("s_write_read", 256'(s_dout), 256'(8'h77));
    check("s_write_valid", 256'(s_vmask), 256'(6'h20));

    // Default instance: reset state
    check("reset_ready", 256'(ready), 256'(1'b1));
    check("reset_valid", 256'(vmask), 256'(8'h00));
    @(posedge clk); #1;
    reset = 1'b0;
    we = 1'b1; wa = 3'd3; din = 32'hDEADBEEF;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b1; ra = 3'd3;
    @(negedge clk);
    check("rd_deadbeef", 256'(dout), 256'(32'hDEADBEEF));
    check("valid_08", 256'(vmask), 256'(8'h08));
    @(posedge clk); #1;
    re = 1'b0;
    @(negedge clk);
    check("rd_disabled", 256'(dout), 256'(32'h0));

    // Same-cycle write/read of addr 2
    @(posedge clk); #1;
    we = 1'b1; wa = 3'd2; din = 32'h1234; re = 1'b1; ra = 3'd2;
    @(negedge clk);
`ifdef REGISTER_BANK_BYPASS_EN
    check("bypass_rd", 256'(dout), 256'(32'h1234));
`else
    check("nobypass_rd", 256'(dout), 256'(32'h0));
`endif
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    check("post_write_rd", 256'(dout), 256'(32'h1234));

    // Bulk clear with a colliding write, junk inputs during clear
    @(posedge clk); #1;
    fill();
    cr = 1'b1; we = 1'b1; wa = 3'd0; din = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    cr = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) break;
      cnt++;
      @(posedge clk); #1;
      we = $urandom; wa = $urandom; din = $urandom; cr = $urandom; re = $urandom; ra = $urandom;
    end
    check("clear_cycles", 256'(cnt), 256'(8));
    check("clear_valid", 256'(vmask), 256'(8'h00));
    check("clear_aodo", aodo, 256'h0);
    @(posedge clk); #1;
    we = 1'b0; cr = 1'b0;

    // Reset three cycles into a clear
    fill();
    cr = 1'b1;
    @(posedge clk); #1;
    cr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; we = 1'b1; cr = 1'b1; wa = 3'd6; din = 32'h0BAD0BAD;
    @(negedge clk);
    check("abort_ready", 256'(ready), 256'(1'b1));
    check("abort_aodo", aodo, 256'h0);
    @(posedge clk); #1;
    reset = 1'b0; cr = 1'b0; we = 1'b1; wa = 3'd5; din = 32'hCAFE0005;
    @(negedge clk);
    check("release_ready", 256'(ready), 256'(1'b1));
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    check("after_abort_wr", 256'(aodo[5*32 +: 32]), 256'(32'hCAFE0005));
    check("after_abort_valid", 256'(vmask), 256'(8'h20));

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      cr    = ($urandom_range(0, 39) == 0);
      we    = $urandom; re = $urandom;
      wa    = $urandom; ra = $urandom; din = $urandom;
    end
    @(posedge clk); #1;
    reset = 1'b0; we = 1'b0; cr = 1'b0;
    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
